// File: rtl/skein1024_pkg.sv
// Shared types and constants for the Skein-1024 UBI datapath.
package skein1024_pkg;

    localparam int SKEIN_WORDS    = 16;
    localparam int SKEIN_KS_WORDS = 17;

    typedef logic [63:0]              word_t;
    typedef word_t [SKEIN_WORDS-1:0]  state_t;

    localparam word_t SKEIN_KS_PARITY = 64'h5555555555555555;

    // Nexus UBI tweaks, packed {t1, t0}
    localparam logic [127:0] SKEIN_NEXUS_TWEAK_BLK0 = {64'hB000000000000000, 64'h00000000000000D8};
    localparam logic [127:0] SKEIN_NEXUS_TWEAK_BLK1 = {64'hFF00000000000000, 64'h0000000000000008};

    localparam int unsigned SKEIN_ROT [8][8] = '{
        '{24, 13,  8, 47,  8, 17, 22, 37},
        '{38, 19, 10, 55, 49, 18, 23, 52},
        '{33,  4, 51, 13, 34, 41, 59, 17},
        '{ 5, 20, 48, 41, 47, 28, 16, 25},
        '{41,  9, 37, 31, 12, 47, 44, 30},
        '{16, 34, 56, 51,  4, 53, 42, 41},
        '{31, 44, 47, 46, 19, 42, 44, 25},
        '{ 9, 48, 35, 52, 23, 31, 37, 20}
    };

    // After the MIX layer, word i takes word SKEIN_PERM[i]
    localparam int unsigned SKEIN_PERM [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINAL,
        ST_DONE
    } ubi_state_e;

    function automatic word_t rotl64(input word_t x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

// File: rtl/skein1024_group4.sv
// Four Threefish-1024 rounds (MIX + word permutation); even_i picks rotation rows 0-3, else 4-7.
module skein1024_group4
    import skein1024_pkg::*;
(
    input  state_t x_i,
    input  logic   even_i,
    output state_t y_o
);

    for (genvar r = 0; r < 4; r++) begin : g_round
        state_t vin;
        state_t mixed;
        state_t vout;

        if (r == 0) begin : g_first
            assign vin = x_i;
        end else begin : g_next
            assign vin = g_round[r-1].vout;
        end

        for (genvar j = 0; j < 8; j++) begin : g_mix
            word_t sum;
            assign sum              = vin[2*j] + vin[2*j+1];
            assign mixed[2*j]       = sum;
            assign mixed[2*j+1]     = sum ^ (even_i ? rotl64(vin[2*j+1], SKEIN_ROT[r][j])
                                                    : rotl64(vin[2*j+1], SKEIN_ROT[r+4][j]));
        end

        for (genvar i = 0; i < SKEIN_WORDS; i++) begin : g_perm
            assign vout[i] = mixed[SKEIN_PERM[i]];
        end
    end

    assign y_o = g_round[3].vout;

endmodule

// File: rtl/skein1024_ubi_iter.sv
// Iterative Skein-1024 UBI block processor, one subkey + 4-round group per cycle.
// Defining SKEIN_UBI_ABORT_EN adds an abort input that drops the block in RUN/FINAL.
//   state    | meaning
//   ST_IDLE  | waiting for a block
//   ST_RUN   | inject subkey s, run group s
//   ST_FINAL | last injection, feedforward, capture result + chain
//   ST_DONE  | result held until out_ready
module skein1024_ubi_iter
    import skein1024_pkg::*;
#(
    parameter int    NUM_GROUPS = 20,
    parameter word_t KS_PARITY  = SKEIN_KS_PARITY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_msg,
    input  logic [1023:0] in_key,
    input  logic          in_chain,
    input  logic [127:0]  in_tweak,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] out_state,
`ifdef SKEIN_UBI_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy
);

    localparam int            CW     = $clog2(NUM_GROUPS + 1);
    localparam logic [CW-1:0] LAST_S = CW'(NUM_GROUPS - 1);

    ubi_state_e                 state_q;
    state_t                     msg_q;
    state_t                     v_q;
    state_t                     chain_q;
    state_t                     out_q;
    word_t [SKEIN_KS_WORDS-1:0] ks_q;
    word_t [2:0]                tw_q;
    logic [CW-1:0]              s_q;
    logic [1:0]                 m_q;
    logic                       out_valid_q;

    state_t                     key_sel;
    state_t                     sk;
    state_t                     keyed;
    state_t                     v_d;
    state_t                     out_d;
    word_t                      parity;
    word_t                      tw_a;
    word_t                      tw_b;
    word_t [SKEIN_KS_WORDS-1:0] ks_d;
    logic                       abort_hit;

`ifdef SKEIN_UBI_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign key_sel = in_chain ? chain_q : state_t'(in_key);
    assign parity  = KS_PARITY ^ key_sel[0]  ^ key_sel[1]  ^ key_sel[2]  ^ key_sel[3]
                               ^ key_sel[4]  ^ key_sel[5]  ^ key_sel[6]  ^ key_sel[7]
                               ^ key_sel[8]  ^ key_sel[9]  ^ key_sel[10] ^ key_sel[11]
                               ^ key_sel[12] ^ key_sel[13] ^ key_sel[14] ^ key_sel[15];
    assign ks_d    = {parity, key_sel};

    // ks_q[i] always holds k[(s+i) mod 17]; m_q tracks s mod 3 for the tweak pair
    always_comb begin
        tw_a = tw_q[0];
        tw_b = tw_q[1];
        case (m_q)
            2'd1: begin
                tw_a = tw_q[1];
                tw_b = tw_q[2];
            end
            2'd2: begin
                tw_a = tw_q[2];
                tw_b = tw_q[0];
            end
            default: ;
        endcase
        sk     = state_t'(ks_q[SKEIN_WORDS-1:0]);
        sk[13] = ks_q[13] + tw_a;
        sk[14] = ks_q[14] + tw_b;
        sk[15] = ks_q[15] + word_t'(s_q);
    end

    for (genvar i = 0; i < SKEIN_WORDS; i++) begin : g_inject
        assign keyed[i] = v_q[i] + sk[i];
    end

    assign out_d = keyed ^ msg_q;

    skein1024_group4 u_group4 (
        .x_i    (keyed),
        .even_i (~s_q[0]),
        .y_o    (v_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            msg_q       <= '0;
            v_q         <= '0;
            chain_q     <= '0;
            out_q       <= '0;
            ks_q        <= '0;
            tw_q        <= '0;
            s_q         <= '0;
            m_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        msg_q   <= state_t'(in_msg);
                        v_q     <= state_t'(in_msg);
                        ks_q    <= ks_d;
                        tw_q    <= {in_tweak[63:0] ^ in_tweak[127:64], in_tweak[127:64], in_tweak[63:0]};
                        s_q     <= '0;
                        m_q     <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_hit) begin
                        state_q <= ST_IDLE;
                    end else begin
                        v_q  <= v_d;
                        ks_q <= {ks_q[0], ks_q[SKEIN_KS_WORDS-1:1]};
                        s_q  <= s_q + CW'(1);
                        m_q  <= (m_q == 2'd2) ? 2'd0 : m_q + 2'd1;
                        if (s_q == LAST_S) begin
                            state_q <= ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    if (abort_hit) begin
                        state_q <= ST_IDLE;
                    end else begin
                        out_q       <= out_d;
                        chain_q     <= out_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_state = out_q;

endmodule

// File: tb/tb_skein1024_ubi_iter.sv
// Directed bench for skein1024_ubi_iter against a plain Threefish-1024 UBI reference.
module tb_skein1024_ubi_iter;

    localparam logic [127:0] TW_BLK0 = {64'hB000000000000000, 64'h00000000000000D8};
    localparam logic [127:0] TW_BLK1 = {64'hFF00000000000000, 64'h0000000000000008};
    localparam logic [63:0]  PARITY  = 64'h5555555555555555;

    localparam int ROT_T [8][8] = '{
        '{24, 13,  8, 47,  8, 17, 22, 37},
        '{38, 19, 10, 55, 49, 18, 23, 52},
        '{33,  4, 51, 13, 34, 41, 59, 17},
        '{ 5, 20, 48, 41, 47, 28, 16, 25},
        '{41,  9, 37, 31, 12, 47, 44, 30},
        '{16, 34, 56, 51,  4, 53, 42, 41},
        '{31, 44, 47, 46, 19, 42, 44, 25},
        '{ 9, 48, 35, 52, 23, 31, 37, 20}
    };
    localparam int PERM_T [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

    logic          clk;
    logic          rst;
    logic          in_valid, in_ready, in_chain, out_valid, out_ready, busy;
    logic [1023:0] in_msg, in_key, out_state;
    logic [127:0]  in_tweak;
    logic          abort;
    logic          in_valid2, in_ready2, in_chain2, out_valid2, out_ready2, busy2;
    logic [1023:0] in_msg2, in_key2, out_state2;
    logic [127:0]  in_tweak2;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    skein1024_ubi_iter #(.NUM_GROUPS(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .in_key    (in_key),
        .in_chain  (in_chain),
        .in_tweak  (in_tweak),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
`ifdef SKEIN_UBI_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    skein1024_ubi_iter #(.NUM_GROUPS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_msg    (in_msg2),
        .in_key    (in_key2),
        .in_chain  (in_chain2),
        .in_tweak  (in_tweak2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_state (out_state2),
`ifdef SKEIN_UBI_ABORT_EN
        .abort     (1'b0),
`endif
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int w;
        n_checks++;
        if (got !== exp) begin
            w = 0;
            for (int i = 15; i >= 0; i--) begin
                if (got[64*i +: 64] !== exp[64*i +: 64]) w = i;
            end
            n_errors++;
            $display("FAIL %s: word %0d got %h expected %h", tag, w, got[64*w +: 64], exp[64*w +: 64]);
        end
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [1023:0] ref_ubi(input logic [1023:0] key, input logic [1023:0] msg,
                                              input logic [127:0] tweak, input int ng);
        logic [63:0]   k [17];
        logic [63:0]   t [3];
        logic [63:0]   v [16];
        logic [63:0]   f [16];
        logic [1023:0] res;
        k[16] = PARITY;
        for (int i = 0; i < 16; i++) begin
            k[i]  = key[64*i +: 64];
            k[16] = k[16] ^ k[i];
            v[i]  = msg[64*i +: 64];
        end
        t[0] = tweak[63:0];
        t[1] = tweak[127:64];
        t[2] = t[0] ^ t[1];
        for (int s = 0; s <= ng; s++) begin
            for (int i = 0; i < 16; i++) v[i] = v[i] + k[(s + i) % 17];
            v[13] = v[13] + t[s % 3];
            v[14] = v[14] + t[(s + 1) % 3];
            v[15] = v[15] + 64'(s);
            if (s < ng) begin
                for (int r = 0; r < 4; r++) begin
                    for (int j = 0; j < 8; j++) begin
                        f[2*j]   = v[2*j] + v[2*j+1];
                        f[2*j+1] = rotl(v[2*j+1], ROT_T[(4*s + r) % 8][j]) ^ f[2*j];
                    end
                    for (int i = 0; i < 16; i++) v[i] = f[PERM_T[i]];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[64*i +: 64] = v[i] ^ msg[64*i +: 64];
        return res;
    endfunction

    // Offer one block to dut; returns the cycle number of the accept edge
    task automatic send(input logic [1023:0] key, input logic [1023:0] msg, input logic chain,
                        input logic [127:0] tw, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_val("send_ready_timeout", in_ready, 1);
        in_key   = key;
        in_msg   = msg;
        in_chain = chain;
        in_tweak = tw;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        in_key   = rand1024();
        in_msg   = rand1024();
        in_tweak = {$urandom, $urandom, $urandom, $urandom};
        in_chain = ~chain;
    endtask

    task automatic wait_out(input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 100 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = cyc - acc;
        end
    endtask

    initial begin
        logic [1023:0] key_a, msg_a, exp_a, exp_b, key_d, msg_d, exp_d, key_e, msg_e, exp_e;
        logic [1023:0] msg_g, exp_g, msg_h, exp_h, exp2, msg2b, exp2b;
        logic [127:0]  tw_d, tw_e, tw2b;
        logic          seen;
        int            acc, acc_prev, lat, rel;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_key     = '0;
        in_msg     = '0;
        in_chain   = 1'b0;
        in_tweak   = '0;
        out_ready  = 1'b0;
        abort      = 1'b0;
        in_valid2  = 1'b0;
        in_key2    = '0;
        in_msg2    = '0;
        in_chain2  = 1'b0;
        in_tweak2  = '0;
        out_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_state", out_state, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", in_ready, 1);

        // Nexus block 0 with a random key, then hold the result under backpressure
        key_a = rand1024();
        msg_a = rand1024();
        exp_a = ref_ubi(key_a, msg_a, TW_BLK0, 20);
        send(key_a, msg_a, 1'b0, TW_BLK0, acc);
        check_val("a_busy", busy, 1);
        wait_out(acc, lat);
        check_val("a_latency", lat, 21);
        check_val("a_state", out_state, exp_a);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_state", out_state, exp_a);
            check_val("bp_valid_ready", {out_valid, in_ready}, 2'b10);
        end

        // Release and offer the chained Nexus block 1 in the same cycle
        exp_b = ref_ubi(exp_a, '0, TW_BLK1, 20);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_chain  = 1'b1;
        in_key    = rand1024();
        in_msg    = '0;
        in_tweak  = TW_BLK1;
        @(posedge clk);
        #1;
        rel       = cyc;
        out_ready = 1'b0;
        check_val("release_valid_ready", {out_valid, in_ready}, 2'b01);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        in_msg   = rand1024();
        in_chain = 1'b0;
        check_val("reaccept_busy", busy, 1);
        check_val("reaccept_gap", acc - rel, 1);
        wait_out(acc, lat);
        check_val("b_latency", lat, 21);
        check_val("b_state", out_state, exp_b);

        // Back-to-back blocks with the consumer always ready
        @(negedge clk);
        out_ready = 1'b1;
        key_d = rand1024();
        msg_d = rand1024();
        tw_d  = {$urandom, $urandom, $urandom, $urandom};
        exp_d = ref_ubi(key_d, msg_d, tw_d, 20);
        send(key_d, msg_d, 1'b0, tw_d, acc);
        wait_out(acc, lat);
        check_val("d_latency", lat, 21);
        check_val("d_state", out_state, exp_d);
        acc_prev = acc;
        key_e = rand1024();
        msg_e = rand1024();
        tw_e  = {$urandom, $urandom, $urandom, $urandom};
        exp_e = ref_ubi(key_e, msg_e, tw_e, 20);
        send(key_e, msg_e, 1'b0, tw_e, acc);
        check_val("throughput", acc - acc_prev, 23);
        wait_out(acc, lat);
        check_val("e_state", out_state, exp_e);

        // Reset in the middle of a block, at s = 7
        send(rand1024(), rand1024(), 1'b0, TW_BLK0, acc);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_val("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_state", out_state, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mid_rel_ready", in_ready, 1);
        msg_g = rand1024();
        exp_g = ref_ubi('0, msg_g, TW_BLK0, 20);
        send(rand1024(), msg_g, 1'b1, TW_BLK0, acc);
        wait_out(acc, lat);
        check_val("g_latency", lat, 21);
        check_val("g_zero_chain_state", out_state, exp_g);

`ifdef SKEIN_UBI_ABORT_EN
        send(rand1024(), rand1024(), 1'b0, TW_BLK1, acc);
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check_val("abort_no_valid", seen, 0);
        msg_h = rand1024();
        exp_h = ref_ubi(exp_g, msg_h, TW_BLK1, 20);
        send(rand1024(), msg_h, 1'b1, TW_BLK1, acc);
        wait_out(acc, lat);
        check_val("abort_chain_state", out_state, exp_h);
`endif

        // Reduced-round instance: all-zero inputs, then a chained block
        exp2 = ref_ubi('0, '0, '0, 2);
        @(negedge clk);
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        acc       = cyc;
        in_valid2 = 1'b0;
        lat       = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid2) lat = cyc - acc;
        end
        check_val("g2_latency", lat, 3);
        check_val("g2_zero_state", out_state2, exp2);
        msg2b = rand1024();
        tw2b  = {$urandom, $urandom, $urandom, $urandom};
        exp2b = ref_ubi(exp2, msg2b, tw2b, 2);
        @(negedge clk);
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        in_chain2  = 1'b1;
        in_key2    = rand1024();
        in_msg2    = msg2b;
        in_tweak2  = tw2b;
        @(posedge clk);
        @(posedge clk);
        #1;
        acc       = cyc;
        in_valid2 = 1'b0;
        in_msg2   = rand1024();
        lat       = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid2) lat = cyc - acc;
        end
        check_val("g2_chain_latency", lat, 3);
        check_val("g2_chain_state", out_state2, exp2b);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
